// File: rtl/ir_packet_scheduler_pkg.sv
// Shared definitions for the IR packet scheduler: FSM encoding, command bit
// positions, grant codes and the default WAIT timeout.
package ir_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArb   = 2'd1,
    StStart = 2'd2,
    StWait  = 2'd3
  } sched_state_e;

  localparam int unsigned CmdFwd   = 0;
  localparam int unsigned CmdBwd   = 1;
  localparam int unsigned CmdLeft  = 2;
  localparam int unsigned CmdRight = 3;

  localparam int unsigned CntWidth             = 24;
  localparam int unsigned DefaultTimeoutCycles = 5000000;

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantA    = 2'b01;
  localparam logic [1:0] GrantB    = 2'b10;

endpackage

// File: rtl/tx_timeout_cnt.sv
// WAIT-state watchdog: counts enabled cycles from a clear and flags the cycle in
// which the count reaches TIMEOUT_CYCLES-1.
module tx_timeout_cnt
  import ir_packet_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic terminal_count
);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign terminal_count = enable && (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ir_packet_scheduler.sv
// Arbitrates two command sources onto a shared IR transmitter, one packet per
// 10 Hz tick, with round-robin tie breaking, overrun and timeout reporting.
module ir_packet_scheduler
  import ir_packet_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_PACKET,
  input  logic       REQ_A,
  input  logic [3:0] CMD_A,
  input  logic       REQ_B,
  input  logic [3:0] CMD_B,
  input  logic       TX_DONE,
  output logic       TX_START,
  output logic [3:0] TX_CMD,
  output logic [1:0] GRANT,
  output logic       OVERRUN,
  output logic       TIMEOUT
);

  sched_state_e state_q;
  logic         last_b_q;
  logic         tx_start_q;
  logic [3:0]   tx_cmd_q;
  logic [1:0]   grant_q;
  logic         overrun_q;
  logic         timeout_q;
  logic         wait_tc;

  // Counter is held clear outside WAIT, so it restarts at zero on every entry.
  tx_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .CLK           (CLK),
    .RESET         (RESET),
    .clear         (state_q != StWait),
    .enable        (state_q == StWait),
    .terminal_count(wait_tc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      last_b_q   <= 1'b1;
      tx_start_q <= 1'b0;
      tx_cmd_q   <= 4'b0000;
      grant_q    <= GrantNone;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (SEND_PACKET) state_q <= StArb;
        end
        StArb: begin
          if (SEND_PACKET) overrun_q <= 1'b1;
          // A wins when alone, or on a tie when B owned the last real packet.
          if (REQ_A && (!REQ_B || last_b_q)) begin
            grant_q  <= GrantA;
            tx_cmd_q <= CMD_A;
            last_b_q <= 1'b0;
          end else if (REQ_B) begin
            grant_q  <= GrantB;
            tx_cmd_q <= CMD_B;
            last_b_q <= 1'b1;
          end else begin
            grant_q  <= GrantNone;
            tx_cmd_q <= 4'b0000;
          end
          state_q <= StStart;
        end
        StStart: begin
          if (SEND_PACKET) overrun_q <= 1'b1;
          tx_start_q <= 1'b1;
          state_q    <= StWait;
        end
        StWait: begin
          if (TX_DONE) begin
            state_q <= SEND_PACKET ? StArb : StIdle;
          end else begin
            if (SEND_PACKET) overrun_q <= 1'b1;
            if (wait_tc) begin
              timeout_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TX_START = tx_start_q;
  assign TX_CMD   = tx_cmd_q;
  assign GRANT    = grant_q;
  assign OVERRUN  = overrun_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Directed plus randomized packet sequences checked against a transaction-level
// model of the arbitration, latency, overrun and timeout rules.
module tb_ir_packet_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_PACKET = 1'b0;
  logic       REQ_A = 1'b0;
  logic [3:0] CMD_A = 4'b0000;
  logic       REQ_B = 1'b0;
  logic [3:0] CMD_B = 4'b0000;
  logic       TX_DONE = 1'b0;
  logic       TX_START;
  logic [3:0] TX_CMD;
  logic [1:0] GRANT;
  logic       OVERRUN;
  logic       TIMEOUT;

  int total = 0;
  int bad = 0;
  bit model_last_b = 1'b1;

  ir_packet_scheduler #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SEND_PACKET(SEND_PACKET),
    .REQ_A      (REQ_A),
    .CMD_A      (CMD_A),
    .REQ_B      (REQ_B),
    .CMD_B      (CMD_B),
    .TX_DONE    (TX_DONE),
    .TX_START   (TX_START),
    .TX_CMD     (TX_CMD),
    .GRANT      (GRANT),
    .OVERRUN    (OVERRUN),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(TX_START), 32'd0);
    check({tag, "_cmd"}, 32'(TX_CMD), 32'd0);
    check({tag, "_grant"}, 32'(GRANT), 32'd0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
    check({tag, "_timeout"}, 32'(TIMEOUT), 32'd0);
  endtask

  // Issue one tick at a negedge and follow the packet until just after TX_START.
  // with_done also pulses TX_DONE in the tick cycle (back-to-back packet).
  task automatic do_tick(input logic ra, input logic rb, input logic [3:0] ca,
                         input logic [3:0] cb, input bit with_done);
    logic [1:0] eg;
    logic [3:0] ec;
    int lat;
    if (ra && rb) eg = model_last_b ? 2'b01 : 2'b10;
    else if (ra) eg = 2'b01;
    else if (rb) eg = 2'b10;
    else eg = 2'b00;
    ec = (eg == 2'b01) ? ca : (eg == 2'b10) ? cb : 4'b0000;
    if (eg != 2'b00) model_last_b = (eg == 2'b10);

    REQ_A = ra; REQ_B = rb; CMD_A = ca; CMD_B = cb;
    SEND_PACKET = 1'b1;
    TX_DONE = with_done;
    @(negedge CLK);
    SEND_PACKET = 1'b0;
    TX_DONE = 1'b0;
    if (with_done) check("chained_no_overrun", 32'(OVERRUN), 32'd0);
    lat = 0;
    while (!TX_START && lat < 6) begin
      @(negedge CLK);
      lat++;
      // Requests already sampled; later changes must not leak into the packet.
      if (lat == 1) begin
        REQ_A = 1'($urandom_range(0, 1));
        REQ_B = 1'($urandom_range(0, 1));
        CMD_A = 4'($urandom());
        CMD_B = 4'($urandom());
      end
    end
    check("start_latency", 32'(lat), 32'd2);
    check("tx_cmd", 32'(TX_CMD), 32'(ec));
    check("grant", 32'(GRANT), 32'(eg));
    @(negedge CLK);
    check("start_pulse_width", 32'(TX_START), 32'd0);
  endtask

  task automatic pulse_done();
    TX_DONE = 1'b1;
    @(negedge CLK);
    TX_DONE = 1'b0;
  endtask

  initial begin
    int k;
    int mode;
    bit chain;
    bit any_start;

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    check_all_zero("reset_hold");
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("no_start_from_reset", 32'(TX_START), 32'd0);

    // First packet after reset, A only
    do_tick(1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0);
    pulse_done();

    // TX_DONE while idle does nothing
    pulse_done();
    any_start = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (TX_START) any_start = 1'b1;
    end
    check("done_in_idle_ignored", 32'(any_start), 32'd0);

    // Idle packet
    do_tick(1'b0, 1'b0, 4'b0101, 4'b1010, 1'b0);
    pulse_done();

    // Timeout with an overrun tick inside WAIT; entry was one negedge ago.
    do_tick(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0);
    k = 1;
    while (k < 40) begin
      if (TIMEOUT) break;
      if (k == 6) begin
        SEND_PACKET = 1'b0;
        check("overrun_in_wait", 32'(OVERRUN), 32'd1);
      end
      if (k == 5) SEND_PACKET = 1'b1;
      @(negedge CLK);
      k++;
    end
    check("timeout_cycles", 32'(k), 32'd16);
    @(negedge CLK);
    check("timeout_pulse_width", 32'(TIMEOUT), 32'd0);
    pulse_done();
    do_tick(1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0);

    // Asynchronous reset mid-WAIT clears everything immediately
    #2;
    RESET = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    model_last_b = 1'b1;
    pulse_done();
    any_start = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (TX_START) any_start = 1'b1;
    end
    check("late_done_ignored", 32'(any_start), 32'd0);

    // Round-robin on ties: A, B, A
    do_tick(1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0);
    pulse_done();
    do_tick(1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0);
    pulse_done();
    do_tick(1'b1, 1'b1, 4'b0001, 4'b1000, 1'b0);

    // TX_DONE with tick in the same cycle starts the next packet
    do_tick(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b1);
    pulse_done();

    // Randomized packet stream
    chain = 1'b0;
    for (int i = 0; i < 30; i++) begin
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom()),
              4'($urandom()), chain);
      chain = 1'b0;
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge CLK);
        pulse_done();
      end else if (mode == 1) begin
        SEND_PACKET = 1'b1;
        @(negedge CLK);
        SEND_PACKET = 1'b0;
        check("rand_overrun", 32'(OVERRUN), 32'd1);
        @(negedge CLK);
        check("rand_overrun_width", 32'(OVERRUN), 32'd0);
        pulse_done();
      end else begin
        chain = 1'b1;
      end
    end
    if (chain) pulse_done();
    repeat (2) @(negedge CLK);
    check("final_no_timeout", 32'(TIMEOUT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
